// File: rtl/window_fetch.sv
// 3x3 window fetcher for 2:1 downsampling: reads nine edge-clamped taps around
// (2*out_x, 2*out_y) and streams them into a window register file.
module window_fetch #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_data,
    output logic [7:0]  reg_data,
    output logic [3:0]  reg_select,
    output logic        write_en,
    output logic        win_valid,
    input  logic        win_ack,
    output logic [7:0]  out_x,
    output logic [7:0]  out_y,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, VALID, DONE} state_t;

    localparam logic [7:0]         OX_LAST = 8'(IMG_W / 2 - 1);
    localparam logic [7:0]         OY_LAST = 8'(IMG_H / 2 - 1);
    localparam logic signed [10:0] X_MAX   = 11'(IMG_W - 1);
    localparam logic signed [10:0] Y_MAX   = 11'(IMG_H - 1);

    state_t state, state_nxt;
    logic [3:0] k;
    logic [3:0] wr_sel;
    logic       wr_pend;
    logic [1:0] row, col;
    logic signed [10:0] tx, ty;
    logic [7:0] x_cl, y_cl;
    logic       last_win;

    assign last_win = (out_x == OX_LAST) && (out_y == OY_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (k == 4'd8) state_nxt = DRAIN;
            DRAIN:   state_nxt = VALID;
            VALID:   if (win_ack) state_nxt = last_win ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tap counter, window position and the one-cycle-delayed write strobe
    // that lines reg_select up with the returning read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            out_x   <= '0;
            out_y   <= '0;
            wr_pend <= 1'b0;
            wr_sel  <= '0;
        end else begin
            wr_pend <= (state == FETCH);
            wr_sel  <= (state == FETCH) ? k : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k     <= '0;
                        out_x <= '0;
                        out_y <= '0;
                    end
                end
                FETCH: k <= k + 4'd1;
                VALID: begin
                    if (win_ack && !last_win) begin
                        k <= '0;
                        if (out_x == OX_LAST) begin
                            out_x <= '0;
                            out_y <= out_y + 8'd1;
                        end else begin
                            out_x <= out_x + 8'd1;
                        end
                    end
                end
                DONE: begin
                    out_x <= '0;
                    out_y <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        {row, col} = 4'b0000;
        case (k)
            4'd0: {row, col} = 4'b0000;
            4'd1: {row, col} = 4'b0001;
            4'd2: {row, col} = 4'b0010;
            4'd3: {row, col} = 4'b0100;
            4'd4: {row, col} = 4'b0101;
            4'd5: {row, col} = 4'b0110;
            4'd6: {row, col} = 4'b1000;
            4'd7: {row, col} = 4'b1001;
            4'd8: {row, col} = 4'b1010;
            default: {row, col} = 4'b0000;
        endcase
    end

    // Edge replication: clamp the signed tap coordinate into the image.
    always_comb begin
        tx = $signed({2'b00, out_x, 1'b0}) + $signed({9'd0, col}) - 11'sd1;
        ty = $signed({2'b00, out_y, 1'b0}) + $signed({9'd0, row}) - 11'sd1;
        if (tx < 11'sd0)      x_cl = '0;
        else if (tx > X_MAX)  x_cl = 8'(IMG_W - 1);
        else                  x_cl = tx[7:0];
        if (ty < 11'sd0)      y_cl = '0;
        else if (ty > Y_MAX)  y_cl = 8'(IMG_H - 1);
        else                  y_cl = ty[7:0];
    end

    always_comb begin
        mem_rd_en = (state == FETCH);
        mem_addr  = '0;
        if (state == FETCH)
            mem_addr = 16'(y_cl) * 16'(IMG_W) + 16'(x_cl);
    end

    assign reg_data   = mem_data;
    assign reg_select = wr_sel;
    assign write_en   = wr_pend;
    assign win_valid  = (state == VALID);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_window_fetch.sv
// Directed bench for window_fetch on an 8x8 image: reset behaviour, tap
// addresses, write sequencing, backpressure and end-of-frame handling.
module tb_window_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        win_ack = 1'b0;
    logic [7:0]  mem_data = '0;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  reg_data;
    logic [3:0]  reg_select;
    logic        write_en;
    logic        win_valid;
    logic [7:0]  out_x;
    logic [7:0]  out_y;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    int n_win = 0;

    int a_first[9] = '{0, 0, 1, 0, 0, 1, 8, 8, 9};
    int a_mid[9]   = '{9, 10, 11, 17, 18, 19, 25, 26, 27};
    int a_last[9]  = '{45, 46, 47, 53, 54, 55, 61, 62, 63};

    window_fetch #(.IMG_W(8), .IMG_H(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
        .reg_data(reg_data), .reg_select(reg_select), .write_en(write_en),
        .win_valid(win_valid), .win_ack(win_ack),
        .out_x(out_x), .out_y(out_y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {mem_addr, mem_rd_en, reg_select, write_en, win_valid,
                    out_x, out_y, busy, done}, 64'd0);
    endtask

    function automatic int tap_addr(input int ox, input int oy, input int k);
        int x, y;
        x = 2 * ox + k % 3 - 1;
        y = 2 * oy + k / 3 - 1;
        if (x < 0) x = 0;
        if (x > 7) x = 7;
        if (y < 0) y = 0;
        if (y > 7) y = 7;
        return y * 8 + x;
    endfunction

    // Entered at posedge+1 of the first FETCH cycle; returns at the negedge
    // of the first VALID cycle (11th cycle counted from the start/ack edge).
    task automatic do_window(input int ox, input int oy);
        int ea;
        logic [7:0] d;
        for (int c = 0; c < 10; c++) begin
            d = (ox == 1 && oy == 1) ? 8'(c) : 8'(c + 32 * ox + 8 * oy + 100);
            mem_data = d;
            if (c == 2) win_ack = 1'b1;
            if (c == 3) start = 1'b1;
            @(negedge clk);
            if (c < 9) begin
                ea = tap_addr(ox, oy, c);
                if (ox == 0 && oy == 0) ea = a_first[c];
                if (ox == 1 && oy == 1) ea = a_mid[c];
                if (ox == 3 && oy == 3) ea = a_last[c];
                check("rd_en", mem_rd_en, 1);
                check("addr", mem_addr, 64'(ea));
            end else begin
                check("drain_rd_en", mem_rd_en, 0);
            end
            check("write_en", write_en, (c >= 1) ? 1 : 0);
            if (c >= 1) begin
                check("reg_select", reg_select, 64'(c - 1));
                check("reg_data", reg_data, d);
            end
            check("early_valid", win_valid, 0);
            check("pos", {out_x, out_y}, {8'(ox), 8'(oy)});
            @(posedge clk);
            #1;
            win_ack = 1'b0;
            start = 1'b0;
        end
        @(negedge clk);
        check("win_valid", win_valid, 1);
        check("valid_busy", {busy, mem_rd_en}, 2'b10);
        check("valid_pos", {out_x, out_y}, {8'(ox), 8'(oy)});
        n_win++;
    endtask

    task automatic ack_window();
        win_ack = 1'b1;
        @(posedge clk);
        #1;
        win_ack = 1'b0;
    endtask

    initial begin
        // Reset held from time 0
        mem_data = 8'hA5;
        #12;
        check_idle("rst_hold");
        check("rst_reg_data", reg_data, 8'hA5);
        @(posedge clk); #1 rst = 1'b0;

        // Reset from an arbitrary point inside a frame
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat ($urandom_range(3, 30)) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_idle("rst_async_rand");
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("post_rst_quiet");
        end

        // First window, then reset in the middle of the next one at k=4
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        do_window(0, 0);
        ack_window();
        repeat (4) @(posedge clk);
        #2;
        check("k4_addr", {mem_rd_en, mem_addr}, {1'b1, 16'(tap_addr(1, 0, 4))});
        rst = 1'b1;
        #1 check_idle("rst_async_k4");
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("post_k4_quiet");
        end

        // Full frame from restart
        n_win = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int oy = 0; oy < 4; oy++) begin
            for (int ox = 0; ox < 4; ox++) begin
                do_window(ox, oy);
                if (ox == 2 && oy == 1) begin
                    for (int i = 0; i < 20; i++) begin
                        @(negedge clk);
                        check("bp_hold", {win_valid, mem_rd_en, write_en, out_x, out_y},
                              {3'b100, 8'd2, 8'd1});
                    end
                end
                ack_window();
            end
        end
        @(negedge clk);
        check("done_pulse", {done, busy, win_valid, mem_rd_en}, 4'b1100);
        @(posedge clk); #1;
        @(negedge clk);
        check("after_done", {done, busy, out_x, out_y}, 18'd0);
        check("win_count", 64'(n_win), 64'd16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("idle_after_frame");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/window_fetch.md
WINDOW_FETCH -- requirements
Module: window_fetch

Interface
REQ-001 SHALL provide parameter IMG_W, default 256: input image width in pixels (even, 4..256).
REQ-002 SHALL provide parameter IMG_H, default 256: input image height in pixels (even, 4..256).
REQ-003 SHALL provide port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port start  input  1  begins one full-frame downsampling pass.
REQ-006 SHALL provide port mem_addr  output  16  data-memory read address.
REQ-007 SHALL provide port mem_rd_en  output  1  data-memory read strobe.
REQ-008 SHALL provide port mem_data  input  8  read data, valid exactly one cycle after mem_rd_en.
REQ-009 SHALL provide port reg_data  output  8  pixel to the window register file.
REQ-010 SHALL provide port reg_select  output  4  window register index 0..8.
REQ-011 SHALL provide port write_en  output  1  window register file write strobe.
REQ-012 SHALL provide port win_valid  output  1  all nine window registers loaded.
REQ-013 SHALL provide port win_ack  input  1  consumer has taken the filtered result.
REQ-014 SHALL provide port out_x  output  8  output (downsampled) column of the current window.
REQ-015 SHALL provide port out_y  output  8  output row of the current window.
REQ-016 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-017 SHALL provide port done  output  1  one-cycle pulse at end of frame.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, VALID, DONE.
REQ-019 SHALL leave IDLE for FETCH on the rising edge where start=1, with out_x=out_y=0 and k=0.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 Window center SHALL be (cx,cy)=(2*out_x, 2*out_y); output grid is IMG_W/2 x IMG_H/2.
REQ-022 Tap k (0..8) SHALL be dy=k/3-1, dx=k%3-1 (row-major, top-left first).
REQ-023 Tap coordinates SHALL clamp to [0,IMG_W-1] / [0,IMG_H-1] (edge replication).
REQ-024 mem_addr SHALL equal y*IMG_W+x for the clamped tap, row-major, zero-extended to 16 bits.
REQ-025 In FETCH, one tap per cycle: mem_rd_en=1, mem_addr=tap k, k increments; after k=8 go to DRAIN.
REQ-026 write_en SHALL be 1 in the cycle after each read (FETCH cycles 2..9 and DRAIN), with reg_select = k of that read.
REQ-027 reg_data SHALL be driven from mem_data combinationally; stable before the falling edge the register file samples on.
REQ-028 DRAIN SHALL last one cycle, then go to VALID; mem_rd_en=0 in DRAIN, VALID, DONE, IDLE.
REQ-029 In VALID, win_valid=1 and out_x/out_y stay constant until win_ack=1 is sampled.
REQ-030 On win_ack in VALID: advance out_x; on wrap to 0 advance out_y; go to FETCH with k=0.
REQ-031 On win_ack in VALID at out_x=IMG_W/2-1, out_y=IMG_H/2-1: go to DONE, not FETCH.
REQ-032 DONE SHALL last one cycle with done=1, then return to IDLE with out_x=out_y=0.
REQ-033 win_ack outside VALID SHALL be ignored.
REQ-034 Minimum window period SHALL be 11 cycles (9 FETCH + 1 DRAIN + 1 VALID).

Reset
REQ-035 rst=1 SHALL force IDLE immediately, independent of clk, from any state including mid-FETCH.
REQ-036 During and after reset all outputs SHALL be 0 (mem_addr, mem_rd_en, reg_select, write_en, win_valid, out_x, out_y, busy, done); reg_data follows mem_data.
REQ-037 After rst falls, no read or write SHALL occur until the next start.

Verification (IMG_W=IMG_H=8)
REQ-038 Reset: rst pulse with random prior state -> all outputs 0, busy=0, no write_en.
REQ-039 First window: start -> addresses 0,0,1,0,0,1,8,8,9; write_en on 9 consecutive cycles with reg_select 0..8; win_valid 11 cycles after start edge.
REQ-040 Interior window out (1,1): addresses 9,10,11,17,18,19,25,26,27; mem_data=k+1 lands at reg_select k.
REQ-041 Backpressure: hold win_ack=0 for 20 cycles in VALID -> win_valid stays 1, no mem_rd_en, out_x/out_y unchanged.
REQ-042 Last window out (3,3): addresses 45,46,47,53,54,55,61,62,63; win_ack -> done=1 for one cycle, then busy=0; 16 windows total.
REQ-043 Reset at FETCH k=4 -> outputs 0 asynchronously; new start restarts at out (0,0), address 0.
